// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus bundle: instruction memory, decoder handshake, execute feedback, status.
// No storage; pure wiring between the sequencer and its environment.
// Decoder backpressure via inst_valid/dec_ready; memory has fixed one-cycle read latency.
interface fetch_sequencer_if;
   logic        start;
   logic [15:0] imem_addr;
   logic        imem_rd_en;
   logic [15:0] imem_rdata;
   logic [15:0] inst_out;
   logic        inst_valid;
   logic        dec_ready;
   logic        exec_done;
   logic        branch_taken;
   logic [11:0] branch_offset;
   logic        jump_en;
   logic [11:0] jump_target;
   logic        redirect;
   logic        halted;
   logic [15:0] pc_out;

   // Sequencer side
   modport master (
      input  start, imem_rdata, dec_ready, exec_done,
             branch_taken, branch_offset, jump_en, jump_target,
      output imem_addr, imem_rd_en, inst_out, inst_valid,
             redirect, halted, pc_out
   );

   // Environment side: memory, decoder, execute stage
   modport slave (
      output start, imem_rdata, dec_ready, exec_done,
             branch_taken, branch_offset, jump_en, jump_target,
      input  imem_addr, imem_rd_en, inst_out, inst_valid,
             redirect, halted, pc_out
   );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: fetch, wait for memory, hand to decoder, wait for execute, redirect.
// Best case 4 cycles per instruction (FETCH, WAIT_MEM, DECODE, EXECUTE); +1 cycle on branch/jump.
// Holds inst_out/inst_valid while dec_ready is low; waits in EXECUTE until exec_done.
module fetch_sequencer #(
   parameter logic [15:0] RESET_PC  = 16'h0000,
   parameter logic [15:0] HALT_WORD = 16'hFFFF
) (
   input  logic              clk,
   input  logic              rst,
   fetch_sequencer_if.master fs
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_FETCH    = 3'd1,
      S_WAIT_MEM = 3'd2,
      S_DECODE   = 3'd3,
      S_EXECUTE  = 3'd4,
      S_REDIRECT = 3'd5,
      S_HALT     = 3'd6
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [15:0] inst_q, inst_d;
   logic [15:0] branch_pc;
   logic [15:0] jump_pc;
   logic        rdata_is_halt;

   // Branch target is a signed word offset scaled by two; jump keeps the top 3 pc bits
   assign branch_pc     = pc_q + {{3{fs.branch_offset[11]}}, fs.branch_offset, 1'b0};
   assign jump_pc       = {pc_q[15:13], fs.jump_target, 1'b0};
   assign rdata_is_halt = (fs.imem_rdata == HALT_WORD);

   // State, pc and held instruction registers; reset wins over everything
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         inst_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         inst_q  <= inst_d;
      end
   end

   // Next-state selection; execute-stage inputs only matter in EXECUTE
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:     if (fs.start) state_d = S_FETCH;
         S_FETCH:    state_d = S_WAIT_MEM;
         S_WAIT_MEM: state_d = rdata_is_halt ? S_HALT : S_DECODE;
         S_DECODE:   if (fs.dec_ready) state_d = S_EXECUTE;
         S_EXECUTE: begin
            if (fs.exec_done) begin
               state_d = (fs.jump_en || fs.branch_taken) ? S_REDIRECT : S_FETCH;
            end
         end
         S_REDIRECT: state_d = S_FETCH;
         S_HALT:     state_d = S_HALT;
         default:    state_d = S_IDLE;
      endcase
   end

   // Datapath update: capture fetched word and advance pc, or take jump/branch target
   always_comb begin
      pc_d   = pc_q;
      inst_d = inst_q;
      case (state_q)
         S_WAIT_MEM: begin
            if (!rdata_is_halt) begin
               inst_d = fs.imem_rdata;
               pc_d   = pc_q + 16'd1;
            end
         end
         S_EXECUTE: begin
            if (fs.exec_done) begin
               if (fs.jump_en) begin
                  pc_d = jump_pc;
               end else if (fs.branch_taken) begin
                  pc_d = branch_pc;
               end
            end
         end
         default: begin
            pc_d   = pc_q;
            inst_d = inst_q;
         end
      endcase
   end

   // Outputs are decoded from state only, so they never combinationally follow inputs
   always_comb begin
      fs.imem_addr  = pc_q;
      fs.pc_out     = pc_q;
      fs.inst_out   = inst_q;
      fs.imem_rd_en = (state_q == S_FETCH);
      fs.inst_valid = (state_q == S_DECODE);
      fs.redirect   = (state_q == S_REDIRECT);
      fs.halted     = (state_q == S_HALT);
   end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, meaning the PC value loaded on reset.
REQ-002 SHALL have parameter HALT_WORD, default 16'hFFFF, meaning the instruction word that stops fetching.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  level; leaves IDLE when high.
REQ-006 imem_addr  output  16  instruction memory word address (= pc).
REQ-007 imem_rd_en  output  1  memory read strobe; read data returned exactly one cycle later.
REQ-008 imem_rdata  input  16  memory read data, valid the cycle after imem_rd_en.
REQ-009 inst_out  output  16  held instruction presented to the decoder.
REQ-010 inst_valid  output  1  inst_out is valid and awaiting decoder acceptance.
REQ-011 dec_ready  input  1  decoder accepts inst_out when high together with inst_valid.
REQ-012 exec_done  input  1  single-cycle pulse; execute stage finished the current instruction.
REQ-013 branch_taken  input  1  sampled only with exec_done; conditional branch taken.
REQ-014 branch_offset  input  12  two's-complement word offset, sampled with exec_done.
REQ-015 jump_en  input  1  sampled only with exec_done; absolute jump.
REQ-016 jump_target  input  12  jump field, sampled with exec_done.
REQ-017 redirect  output  1  one-cycle pulse when pc is loaded from a branch or jump.
REQ-018 halted  output  1  high while in HALT.
REQ-019 pc_out  output  16  current pc, for debug.

Function
REQ-020 SHALL implement states IDLE, FETCH, WAIT_MEM, DECODE, EXECUTE, REDIRECT and HALT, one state per cycle except where it waits.
REQ-021 IDLE SHALL go to FETCH in the cycle after start is sampled high; otherwise it stays in IDLE.
REQ-022 FETCH SHALL assert imem_rd_en with imem_addr=pc for exactly one cycle, then go to WAIT_MEM.
REQ-023 WAIT_MEM SHALL compare imem_rdata with HALT_WORD:
- on a match: go to HALT, leave pc unchanged, keep inst_valid low;
- otherwise: load inst_out, set pc=pc+1 (mod 2^16), assert inst_valid, go to DECODE.
REQ-024 DECODE SHALL hold inst_out and inst_valid stable until dec_ready=1; in that cycle it clears inst_valid and goes to EXECUTE.
REQ-025 EXECUTE SHALL wait for exec_done, then select the next pc in this priority order:
- jump_en: pc[12:0]={jump_target,1'b0}, pc[15:13] unchanged, go to REDIRECT;
- else branch_taken: pc=pc+(sign_extend(branch_offset)<<1), mod 2^16, go to REDIRECT;
- else: go to FETCH.
REQ-026 jump_en=1 together with branch_taken=1 SHALL perform the jump only.
REQ-027 REDIRECT SHALL pulse redirect for one cycle, then go to FETCH.
REQ-028 Best-case throughput SHALL be one instruction per 4 cycles (FETCH, WAIT_MEM, DECODE with dec_ready=1, EXECUTE with exec_done=1).
REQ-029 HALT SHALL hold halted=1, drive imem_rd_en=0 and inst_valid=0, and be left only by reset.
REQ-030 exec_done, branch_taken and jump_en SHALL be ignored in every state other than EXECUTE.
REQ-031 pc arithmetic SHALL wrap modulo 2^16 with no error indication; 16'hFFFF+1 gives 16'h0000.

Reset
REQ-032 On rst=1 at a clock edge, from any state and including mid-fetch or mid-decode, the block SHALL:
- enter IDLE and set pc=RESET_PC;
- drive inst_out=0, inst_valid=0, imem_rd_en=0, redirect=0, halted=0.
REQ-033 rst SHALL take priority over every other input in the same cycle.
REQ-034 Read data arriving after reset from a read issued before reset SHALL be discarded.

Verification
REQ-035 Straight line: mem[0..2]={16'h1111,16'h2222,16'hFFFF}, start=1, dec_ready=1, exec_done pulsed in each EXECUTE -> inst_out 1111 then 2222, then halted=1 with pc_out=2.
REQ-036 Taken branch: the instruction at pc 4 executes with branch_taken=1 and branch_offset=12'hFFE (-2) -> redirect pulses and the next imem_addr is 5-4=1.
REQ-037 Jump beats branch: pc=16'hA003 at exec_done, jump_en=1, jump_target=12'h010, branch_taken=1 -> next imem_addr=16'hA020.
REQ-038 Decoder stall: dec_ready held low for 5 cycles -> inst_out stable and inst_valid=1 throughout; EXECUTE is entered the cycle after dec_ready rises.
REQ-039 Reset mid-operation: rst asserted during WAIT_MEM -> next cycle state is IDLE, pc=RESET_PC, inst_valid=0, and the stale read data does not appear on inst_out.
REQ-040 Wrap-around: pc=16'hFFFF, fetch a non-halt word -> pc=16'h0000 and the next fetch address is 16'h0000.
